// File: rtl/fifo_stream_drain_if.sv
// Purpose: FIFO read-port and valid/ready output-stream bundle for fifo_stream_drain.
// Ports:   master = drain side (issues fifo_rd_en, drives m_valid/m_data);
//          slave  = environment side (FIFO flags/data, downstream m_ready).
interface fifo_stream_drain_if #(
    parameter int W = 16
);
    // FIFO read port
    logic         fifo_rd_en;
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_underflow;
    // Output stream
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Purpose: read-side FIFO consumer; absorbs the 1-cycle FIFO read latency and
//          re-presents words on a valid/ready stream through a small skid buffer.
// Latency: fifo_rd_en at cycle N -> m_valid earliest at cycle N+2.
// Backpressure: reads are credit-limited ((occ + inflight) < SKID_DEPTH), never
//          gated by m_ready, so a granted read always has a buffer slot waiting.
// Ports:   clk, rst_n (async active-low), drain_en, bus (fifo_stream_drain_if.master:
//          fifo_rd_en/fifo_empty/fifo_data_out/fifo_underflow, m_valid/m_data/m_ready),
//          busy, err_underflow (sticky).
// Option:  FIFO_DRAIN_STATS_EN adds beat_count[31:0] (accepted words) and
//          drop_count[15:0] (underflow-discarded beats); both wrap.
module fifo_stream_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      drain_en,
    fifo_stream_drain_if.master       bus,
    output logic                      busy,
    output logic                      err_underflow
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]               beat_count,
    output logic [15:0]               drop_count
`endif
);

    localparam int PW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OW    = $clog2(SKID_DEPTH + 1);
    // Storage is rounded up to a power of two so any pointer value indexes a real
    // entry; only entries 0..SKID_DEPTH-1 are ever written or read.
    localparam int BUF_N = 1 << PW;
    localparam logic [OW:0]   DEPTH_L = (OW + 1)'(SKID_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FIFO_WIDTH-1:0] r_buf [BUF_N];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_occ;
    logic [OW-1:0]         w_occ_nxt;
    logic                  r_inflight;
    logic                  r_err;
    logic [OW:0]           w_used;
    logic                  w_rd_en;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // Slots already committed: buffered words plus the one read still in flight.
    assign w_used  = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight};
    assign w_valid = (r_occ != '0);
    // An in-flight beat flagged as underflow is dropped instead of stored.
    assign w_push  = r_inflight && !bus.fifo_underflow;
    assign w_pop   = w_valid && bus.m_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + OW'(1);
            2'b01:   w_occ_nxt = r_occ - OW'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // HOLD issues no reads, so inflight is 0 next cycle; looking at next occupancy
    // lets the FSM reach IDLE in the cycle right after the final pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (drain_en) w_state_nxt = S_RUN;
            S_RUN:  if (!drain_en) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (drain_en)                w_state_nxt = S_RUN;
                else if (w_occ_nxt == '0)    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Read request depends only on registered state, drain_en and fifo_empty.
    always_comb begin
        busy    = (r_state != S_IDLE);
        w_rd_en = drain_en && !bus.fifo_empty && (r_state == S_RUN) && (w_used < DEPTH_L);
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_valid ? r_buf[r_rd_ptr] : '0;
    assign err_underflow  = r_err;

    // ---------------- datapath state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_occ      <= w_occ_nxt;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (r_inflight && bus.fifo_underflow) r_err <= 1'b1;
        end
    end

    // Buffer contents need no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_ptr] <= bus.fifo_data_out;
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] r_beat_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop) r_beat_count <= r_beat_count + 32'd1;
            if (r_inflight && bus.fifo_underflow) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign beat_count = r_beat_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;
    localparam int W = 16;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drain_en = 1'b0;
    logic busy;
    logic err_underflow;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] beat_count;
    logic [15:0] drop_count;
`endif

    fifo_stream_drain_if #(.W(W)) ifc ();

    fifo_stream_drain #(.FIFO_WIDTH(W), .SKID_DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .drain_en      (drain_en),
        .bus           (ifc),
        .busy          (busy),
        .err_underflow (err_underflow)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .beat_count    (beat_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a FIFO of words, the ordered list of words the DUT owes
    // downstream, and a count of words read but not yet delivered or dropped.
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    int   outstanding = 0;
    int   acc_total   = 0;
    int   rd_pulses   = 0;
    logic prev_rd     = 1'b0;
    logic force_uf    = 1'b0;

    logic         s_rd, s_v, s_busy, s_acc;
    logic [W-1:0] s_d;

    typedef struct {
        logic         de;
        logic         mr;
        logic         rd;
        logic         v;
        logic [W-1:0] d;
        logic         bz;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic de, input logic mr, input logic rd,
                                input logic v, input logic [W-1:0] d, input logic bz);
        vec_t r;
        r.de = de; r.mr = mr; r.rd = rd; r.v = v; r.d = d; r.bz = bz;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        fq.push_back(w);
        ifc.fifo_empty = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        prev_rd = 1'b0;
        force_uf = 1'b0;
        ifc.fifo_underflow = 1'b0;
    endtask

    // One clock cycle: sample DUT outputs mid-cycle, score them, then play the
    // FIFO's registered read response just after the edge.
    task automatic tick();
        logic uf_now;
        #1;
        s_rd   = ifc.fifo_rd_en;
        s_v    = ifc.m_valid;
        s_d    = ifc.m_data;
        s_busy = busy;
        s_acc  = s_v && ifc.m_ready;
        if (s_acc) begin
            acc_total++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL order: got word 0x%0h expected no word", s_d);
            end else begin
                chk("order", s_d, exp_q.pop_front());
            end
        end
        if (s_rd) rd_pulses++;
        uf_now = prev_rd && ifc.fifo_underflow;
        outstanding = outstanding + int'(s_rd) - int'(s_acc) - int'(uf_now);
        chk("credit_exceeded", outstanding > D, 1'b0);
        @(posedge clk);
        #1;
        ifc.fifo_underflow = 1'b0;
        if (s_rd) begin
            if (fq.size() == 0) begin
                ifc.fifo_underflow = 1'b1;
            end else begin
                ifc.fifo_data_out = fq.pop_front();
                if (force_uf) begin
                    ifc.fifo_underflow = 1'b1;
                    force_uf = 1'b0;
                end else begin
                    exp_q.push_back(ifc.fifo_data_out);
                end
            end
        end
        prev_rd = s_rd;
        ifc.fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        int base;
        ifc.fifo_empty     = 1'b1;
        ifc.fifo_data_out  = '0;
        ifc.fifo_underflow = 1'b0;
        ifc.m_ready        = 1'b0;

        // ---- reset state ----
        #2;
        chk("rst_rd_en", ifc.fifo_rd_en, 1'b0);
        chk("rst_m_valid", ifc.m_valid, 1'b0);
        chk("rst_m_data", ifc.m_data, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_underflow, 1'b0);
`ifdef FIFO_DRAIN_STATS_EN
        chk("rst_beat_count", beat_count, 0);
        chk("rst_drop_count", drop_count, 0);
`endif

        // ---- 1: preloaded 1..8, full throughput, per-cycle table ----
        tbl[0]  = mk(1, 1, 0, 0, 16'h0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 16'h0, 1);
        tbl[2]  = mk(1, 1, 1, 0, 16'h0, 1);
        tbl[3]  = mk(1, 1, 1, 1, 16'h1, 1);
        tbl[4]  = mk(1, 1, 1, 1, 16'h2, 1);
        tbl[5]  = mk(1, 1, 1, 1, 16'h3, 1);
        tbl[6]  = mk(1, 1, 1, 1, 16'h4, 1);
        tbl[7]  = mk(1, 1, 1, 1, 16'h5, 1);
        tbl[8]  = mk(1, 1, 1, 1, 16'h6, 1);
        tbl[9]  = mk(1, 1, 0, 1, 16'h7, 1);
        tbl[10] = mk(1, 1, 0, 1, 16'h8, 1);
        tbl[11] = mk(1, 1, 0, 0, 16'h0, 1);
        for (int i = 1; i <= 8; i++) load(W'(i));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            drain_en    = tbl[i].de;
            ifc.m_ready = tbl[i].mr;
            tick();
            chk($sformatf("t1_rd_en[%0d]", i), s_rd, tbl[i].rd);
            chk($sformatf("t1_valid[%0d]", i), s_v, tbl[i].v);
            chk($sformatf("t1_busy[%0d]", i), s_busy, tbl[i].bz);
            if (tbl[i].v) chk($sformatf("t1_data[%0d]", i), s_d, tbl[i].d);
        end

        // ---- 2: backpressure fills the buffer with exactly SKID_DEPTH reads ----
        for (int i = 1; i <= 8; i++) load(W'(16'h0010 + i));
        ifc.m_ready = 1'b0;
        rd_pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (s_v) chk("t2_data_stable", s_d, 16'h0011);
        end
        chk("t2_rd_pulses", rd_pulses, 3);
        chk("t2_outstanding", outstanding, 3);
        chk("t2_valid", ifc.m_valid, 1'b1);
        ifc.m_ready = 1'b1;
        base = acc_total;
        for (int k = 0; k < 40 && (acc_total - base) < 8; k++) tick();
        chk("t2_delivered", acc_total - base, 8);
        chk("t2_left_over", exp_q.size(), 0);

        // ---- 3: drain_en drops after a read; in-flight word kept, then IDLE ----
        for (int i = 1; i <= 4; i++) load(W'(16'h0020 + i));
        ifc.m_ready = 1'b0;
        rd_pulses = 0;
        tick();
        chk("t3_read", s_rd, 1'b1);
        drain_en = 1'b0;
        tick();
        chk("t3_no_read", s_rd, 1'b0);
        tick();
        chk("t3_hold_valid", s_v, 1'b1);
        chk("t3_hold_data", s_d, 16'h0021);
        chk("t3_hold_busy", s_busy, 1'b1);
        chk("t3_hold_no_read", s_rd, 1'b0);
        ifc.m_ready = 1'b1;
        base = acc_total;
        for (int k = 0; k < 10 && acc_total == base; k++) tick();
        chk("t3_popped", acc_total - base, 1);
        tick();
        chk("t3_idle_busy", s_busy, 1'b0);
        chk("t3_idle_valid", s_v, 1'b0);
        chk("t3_single_read", rd_pulses, 1);
        fq.delete();
        ifc.fifo_empty = 1'b1;

        // ---- 4: underflow on a read response ----
        force_uf = 1'b1;
        load(16'h0031);
        load(16'h0032);
        drain_en = 1'b1;
        base = acc_total;
        for (int k = 0; k < 20 && !(fq.size() == 0 && outstanding == 0); k++) tick();
        chk("t4_delivered", acc_total - base, 1);
        chk("t4_err", err_underflow, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        chk("t4_err_sticky", err_underflow, 1'b1);
`ifdef FIFO_DRAIN_STATS_EN
        chk("t4_drop_count", drop_count, 1);
`endif

        // ---- 5: asynchronous reset with occ=2, inflight=1 ----
        for (int i = 1; i <= 5; i++) load(W'(16'h0040 + i));
        ifc.m_ready = 1'b0;
        rd_pulses = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("t5_reads", rd_pulses, 3);
        chk("t5_outstanding", outstanding, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", ifc.m_valid, 1'b0);
        chk("t5_rst_data", ifc.m_data, 16'h0);
        chk("t5_rst_rd_en", ifc.fifo_rd_en, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_err", err_underflow, 1'b0);
        model_reset();
        #3;
        rst_n = 1'b1;
        ifc.m_ready = 1'b1;
        @(posedge clk);
        #1;
        base = acc_total;
        for (int k = 0; k < 20 && acc_total == base; k++) tick();
        chk("t5_first_word", s_d, 16'h0044);
        for (int k = 0; k < 20 && !(fq.size() == 0 && outstanding == 0); k++) tick();
        chk("t5_delivered", acc_total - base, 2);

        // ---- 6: random backpressure, 200 words ----
        #2;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 200; i++) load(W'($urandom));
        base = acc_total;
        for (int k = 0; k < 3000 && (acc_total - base) < 200; k++) begin
            ifc.m_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("t6_delivered", acc_total - base, 200);
        chk("t6_left_over", exp_q.size(), 0);
`ifdef FIFO_DRAIN_STATS_EN
        chk("t6_beat_count", beat_count, 200);
        chk("t6_drop_count", drop_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
